// File: rtl/delay_ffr_tap.sv
// Tapped delay line with stall, per-stage valid, flush and pending count.
// Define DELAY_FFR_TAP_OUTREG_EN to register out/out_valid/pending (+1 clk latency).
module delay_ffr_tap #(
   parameter int unsigned MAX_DELAY = 8,
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned TAP_W     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic [TAP_W-1:0] tap,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [TAP_W:0]   pending
);

   localparam logic [TAP_W-1:0] TapMax = TAP_W'(MAX_DELAY - 1);

   logic [WIDTH-1:0]     stage_data_q [MAX_DELAY];
   logic [MAX_DELAY-1:0] stage_valid_q;

   logic [TAP_W-1:0] tap_eff;
   logic [WIDTH-1:0] mux_data;
   logic             mux_valid;
   logic [TAP_W:0]   mux_count;

   // Stage storage: reset and flush share one clear path and outrank advance.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < int'(MAX_DELAY); i++) begin
            stage_data_q[i] <= '0;
         end
         stage_valid_q <= '0;
      end else if (en) begin
         stage_data_q[0]  <= in;
         stage_valid_q[0] <= in_valid;
         for (int i = 1; i < int'(MAX_DELAY); i++) begin
            stage_data_q[i]  <= stage_data_q[i-1];
            stage_valid_q[i] <= stage_valid_q[i-1];
         end
      end
   end

   // Out-of-range taps clamp to the last stage so the mux never indexes past the array.
   assign tap_eff = (tap > TapMax) ? TapMax : tap;

   always_comb begin
      mux_data  = '0;
      mux_valid = 1'b0;
      mux_count = '0;
      for (int i = 0; i < int'(MAX_DELAY); i++) begin
         if (TAP_W'(i) == tap_eff) begin
            mux_data  = stage_data_q[i];
            mux_valid = stage_valid_q[i];
         end
         if (TAP_W'(i) <= tap_eff) begin
            mux_count = mux_count + (TAP_W+1)'(stage_valid_q[i]);
         end
      end
   end

`ifdef DELAY_FFR_TAP_OUTREG_EN
   logic [WIDTH-1:0] out_q;
   logic             out_valid_q;
   logic [TAP_W:0]   pending_q;

   // Output registers load every clock, regardless of en.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         pending_q   <= '0;
      end else begin
         out_q       <= mux_data;
         out_valid_q <= mux_valid;
         pending_q   <= mux_count;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign pending   = pending_q;
`else
   assign out       = mux_data;
   assign out_valid = mux_valid;
   assign pending   = mux_count;
`endif

endmodule

// File: tb/tb_delay_ffr_tap.sv
// Self-checking bench for delay_ffr_tap against a queue-based history model.
module tb_delay_ffr_tap;

   localparam int MD = 8;
   localparam int W  = 8;
   localparam int TW = 4;
`ifdef DELAY_FFR_TAP_OUTREG_EN
   localparam int Lat = 1;
`else
   localparam int Lat = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  din = '0;
   logic [TW-1:0] tap = '0;
   logic [W-1:0]  out;
   logic          out_valid;
   logic [TW:0]   pending;

   int checks = 0;
   int errors = 0;

   delay_ffr_tap #(.MAX_DELAY(MD), .WIDTH(W), .TAP_W(TW)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in        (din),
      .tap       (tap),
      .out       (out),
      .out_valid (out_valid),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // Model: history of the last MD advanced samples, newest at the back.
   logic [W-1:0] hist_d [$];
   bit           hist_v [$];
   logic [W-1:0] reg_out;
   logic         reg_val;
   logic [TW:0]  reg_pend;
   logic [W-1:0] e_out;
   logic         e_val;
   logic [TW:0]  e_pend;

   function automatic int clamp_tap(input int t);
      return (t > MD - 1) ? MD - 1 : t;
   endfunction

   function automatic logic [W-1:0] model_out(input int t);
      return hist_d[MD-1-clamp_tap(t)];
   endfunction

   function automatic logic model_val(input int t);
      return hist_v[MD-1-clamp_tap(t)];
   endfunction

   function automatic logic [TW:0] model_pend(input int t);
      int n = 0;
      for (int i = 0; i <= clamp_tap(t); i++) n += int'(hist_v[MD-1-i]);
      return (TW+1)'(n);
   endfunction

   task automatic model_clear();
      hist_d.delete();
      hist_v.delete();
      for (int i = 0; i < MD; i++) begin
         hist_d.push_back('0);
         hist_v.push_back(1'b0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset || flush) begin
         reg_out  = '0;
         reg_val  = 1'b0;
         reg_pend = '0;
         model_clear();
      end else begin
         reg_out  = model_out(int'(tap));
         reg_val  = model_val(int'(tap));
         reg_pend = model_pend(int'(tap));
         if (en) begin
            hist_d.push_back(din);
            hist_v.push_back(in_valid);
            void'(hist_d.pop_front());
            void'(hist_v.pop_front());
         end
      end
      #1;
   endtask

   task automatic expect_now();
`ifdef DELAY_FFR_TAP_OUTREG_EN
      e_out  = reg_out;
      e_val  = reg_val;
      e_pend = reg_pend;
`else
      e_out  = model_out(int'(tap));
      e_val  = model_val(int'(tap));
      e_pend = model_pend(int'(tap));
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b1; in_valid = 1'b1; din = 8'h5A; tap = 4'd3;
      tick();
      tick();
      checks++;
      if (out !== '0 || out_valid !== 1'b0 || pending !== '0) begin
         errors++;
         $display("FAIL reset: out=%h valid=%b pending=%0d, required 0/0/0", out, out_valid, pending);
      end
      reset = 1'b0;
   endtask

   task automatic test_latency();
      tap = 4'd3; en = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         din = 8'h10 + W'(k);
         tick();
         checks++;
         if (k + 1 < 4 + Lat) begin
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL latency_early k=%0d: out_valid=%b, required 0", k, out_valid);
            end
         end else if (out !== 8'h10 + W'(k + 1 - 4 - Lat) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency k=%0d: out=%h valid=%b, required %h/1", k, out, out_valid,
                     8'h10 + W'(k + 1 - 4 - Lat));
         end
      end
      checks++;
      if (pending !== 5'd4) begin
         errors++;
         $display("FAIL latency_pending: pending=%0d, required 4", pending);
      end
   endtask

   task automatic test_stall();
      int n = 0;
      flush = 1'b1; tick(); flush = 1'b0;
      tap = 4'd2; in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         en = (c % 2 == 0);
         din = 8'hA0 + W'(n);
         if (en) n++;
         tick();
         expect_now();
         checks++;
         if (out !== e_out || out_valid !== e_val || pending !== e_pend) begin
            errors++;
            $display("FAIL stall c=%0d: out=%h v=%b p=%0d, required %h/%b/%0d", c, out,
                     out_valid, pending, e_out, e_val, e_pend);
         end
         if (c == 4 + Lat) begin
            checks++;
            if (out !== 8'hA0 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_first: out=%h valid=%b, required a0/1", out, out_valid);
            end
         end
      end
   endtask

   task automatic test_flush();
      tap = 4'd7; en = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         din = W'($urandom_range(0, 254));
         tick();
      end
      flush = 1'b1; din = 8'hFF;
      tick();
      flush = 1'b0;
      checks++;
      if (out !== '0 || out_valid !== 1'b0 || pending !== '0) begin
         errors++;
         $display("FAIL flush: out=%h valid=%b pending=%0d, required 0/0/0", out, out_valid, pending);
      end
      for (int k = 0; k < 10; k++) begin
         din = W'($urandom_range(0, 254));
         tick();
         checks++;
         if (out === 8'hFF) begin
            errors++;
            $display("FAIL flush_leak k=%0d: out=%h, required not ff", k, out);
         end
      end
   endtask

   task automatic test_tap_switch();
      tap = 4'd5; en = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         din = W'($urandom);
         in_valid = 1'($urandom);
         tick();
      end
      en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tap = (j == 0) ? 4'd1 : (j == 1) ? 4'd9 : 4'd15;
         #1;
         expect_now();
         checks++;
         if (out !== e_out || out_valid !== e_val || pending !== e_pend) begin
            errors++;
            $display("FAIL tap_switch tap=%0d: out=%h v=%b p=%0d, required %h/%b/%0d", tap, out,
                     out_valid, pending, e_out, e_val, e_pend);
         end
         tick();
      end
   endtask

   task automatic test_alt_valid();
      tap = 4'd3; en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         in_valid = (k % 2 == 0);
         din = W'($urandom);
         tick();
         expect_now();
         checks++;
         if (out !== e_out || out_valid !== e_val || pending !== e_pend) begin
            errors++;
            $display("FAIL alt_valid k=%0d: out=%h v=%b p=%0d, required %h/%b/%0d", k, out,
                     out_valid, pending, e_out, e_val, e_pend);
         end
      end
      checks++;
      if (pending !== 5'd2) begin
         errors++;
         $display("FAIL alt_pending: pending=%0d, required 2", pending);
      end
   endtask

   task automatic test_reset_mid();
      tap = 4'd4; en = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         din = W'($urandom);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (out !== '0 || out_valid !== 1'b0 || pending !== '0) begin
         errors++;
         $display("FAIL reset_mid: out=%h valid=%b pending=%0d, required 0/0/0", out, out_valid,
                  pending);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         en       = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 40) == 0);
         reset    = ($urandom_range(0, 80) == 0);
         in_valid = 1'($urandom);
         din      = W'($urandom);
         tap      = TW'($urandom);
         tick();
         expect_now();
         checks++;
         if (out !== e_out || out_valid !== e_val || pending !== e_pend) begin
            errors++;
            $display("FAIL random k=%0d tap=%0d: out=%h v=%b p=%0d, required %h/%b/%0d", k, tap,
                     out, out_valid, pending, e_out, e_val, e_pend);
         end
      end
      reset = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      model_clear();
      reg_out = '0; reg_val = 1'b0; reg_pend = '0;
      test_reset();
      test_latency();
      test_stall();
      test_flush();
      test_tap_switch();
      test_alt_valid();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
